mul_div_arbiter: RTL and testbench
==================================

// Module: mul_div_arbiter
// PURPOSE
//  Shares one pipelined FP32 multiply/divide core (a, b, sel, en -> R + 5 flags) among N_REQ requesters.
//  Each requester uses a valid/ready request channel. The block grants round-robin, issues at most one op/cycle,
//  and tags each issued op. It routes core_R/flags back to the issuing requester after LATENCY cycles.
//  Sits between client engines and the mul_div core; the core itself is not modified.
// PARAMETERS
//  N_REQ    2   number of requesters (2..8)
//  LATENCY  2   cycles from core_en-sampling edge to core_R/flags valid (1..8)
// PORTS
//  clk          in   1          single clock, all logic on posedge
//  arst         in   1          asynchronous reset, active-high
//  req_valid    in   N_REQ      request pending per requester
//  req_ready    out  N_REQ      one-hot grant; handshake completes when valid&ready
//  req_sel      in   N_REQ      0=multiply, 1=divide, per requester
//  req_a        in   32*N_REQ   operand a, requester i in [32*i+:32]
//  req_b        in   32*N_REQ   operand b, same packing
//  rsp_valid    out  N_REQ      one-cycle pulse: result for requester i present
//  rsp_R        out  32         result (shared bus, qualified by rsp_valid)
//  rsp_flags    out  5          {io,dz,of,uf,i} flags (shared, qualified by rsp_valid)
//  busy         out  1          1 while any op is in flight or being issued
//  sticky_clr   in   N_REQ      clear sticky flags of requester i (feature-dependent)
//  sticky_flags out  5*N_REQ    accumulated flags per requester (feature-dependent)
//  core_en      out  1          issue strobe to core
//  core_sel     out  1          op select to core
//  core_a       out  32         operand a to core
//  core_b       out  32         operand b to core
//  core_R       in   32         core result
//  core_flags   in   5          core {io_flag,dz_flag,of_flag,uf_flag,i_flag}
// BEHAVIOUR
//  Reset values (arst=1, immediate):
//   - req_ready, rsp_valid, rsp_R, rsp_flags, sticky_flags, core_en, core_sel, core_a, core_b = 0; busy=0.
//   - RR pointer = 0; tag pipe cleared.
//  Arbitration (combinational within cycle):
//   - Grant goes to the first i with req_valid[i], searching from ptr upward mod N_REQ.
//   - req_ready = grant (at most one bit set). No valid -> no grant, core_en=0.
//   - After a grant to i: ptr <= (i+1) mod N_REQ. No grant -> ptr unchanged.
//   - Requester must hold valid/sel/a/b stable until ready; dropping valid early is illegal (bench asserts).
//  Issue:
//   - On grant cycle t: core_en=1; core_sel/a/b = granted requester's fields.
//   - When idle, core_a/b/sel hold their last issued values; core_en=0.
//  Tag pipe (registered):
//   - LATENCY-deep shift register of {vld, id[$clog2(N_REQ)-1:0]}, shifts every cycle, stage0 <= {core_en, grant_id}.
//   - Core output is captured on the cycle the tag exits. The capture registers rsp_R/rsp_flags and pulses rsp_valid[id].
//   - Response therefore appears at cycle t+LATENCY+1 after the issue cycle; throughput is 1 op/cycle.
//   - No response backpressure: requester must accept rsp_valid pulse.
//   - rsp_R/rsp_flags hold their value between pulses.
//  busy = core_en | any tag vld | any rsp_valid.
//  Simultaneous issue and response in the same cycle are independent; both occur.
//  arst mid-operation: in-flight ops are discarded; no rsp_valid for them after reset release.
// CONFIGURATION
//  MUL_DIV_ARB_STICKY_FLAGS_EN defined:
//   - On each rsp_valid[i], sticky_flags[5*i+:5] |= rsp_flags (registered).
//   - sticky_clr[i] zeros that slice next edge; clear wins over a same-cycle set.
//  Undefined: sticky_flags tied 0, sticky_clr ignored; ports remain present.
// TESTING
//  1 Reset: arst pulse mid-stream with 2 ops in flight -> all outputs 0, no rsp_valid after release.
//  2 Single op: req0 a=0x40000000 b=0x40400000 sel=0, LATENCY=2 -> ready0 at t; rsp_valid[0] at t+3;
//    rsp_R=0x40C00000, flags=0.
//  3 Contention: req0 & req1 valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; responses keep that order
//    with correct ids.
//  4 Divide by zero: req1 a=0x3F800000 b=0 sel=1 -> rsp_valid[1], dz_flag=1. With STICKY_EN: sticky[1].dz stays 1
//    until sticky_clr[1].
//  5 Back-to-back: req1 only, valid 4 cycles with distinct operands -> 4 consecutive rsp_valid[1] pulses, 1/cycle, in order.
//  6 Sticky clear collision: sticky_clr[0] in same cycle as rsp_valid[0] with of=1 -> sticky[0]=0 (clear wins).

Source files
------------

// File: rtl/mul_div_arbiter.sv
// mul_div_arbiter
//   Shares one pipelined FP32 multiply/divide core among N_REQ requesters.
//   Requests are granted round-robin, one issue per cycle. Each issued op is
//   tagged with its requester id. The tag travels down a LATENCY-deep pipe
//   that runs in step with the core. When the tag leaves the pipe, the core
//   result is captured and a one-cycle rsp_valid pulse goes to the owner.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   LATENCY  core cycles from the core_en sampling edge to core_R valid (1..8)
//
// Ports
//   clk, arst                  clock; asynchronous active-high reset
//   req_valid/ready/sel/a/b    per-requester request channel (a/b packed 32*i)
//   rsp_valid                  one-hot response pulse, per requester
//   rsp_R, rsp_flags           shared response bus, held between pulses
//   busy                       op being issued, in flight or being returned
//   sticky_clr, sticky_flags   per-requester accumulated {io,dz,of,uf,i}
//   core_en/sel/a/b            issue interface to the core
//   core_R, core_flags         core result interface
//
// Optional feature
//   MUL_DIV_ARB_STICKY_FLAGS_EN : when defined, response flags accumulate per
//   requester. When undefined, sticky_flags reads 0 and sticky_clr is ignored.

module mul_div_arbiter #(
    parameter int N_REQ   = 2,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ-1:0]     req_sel,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_R,
    output logic [4:0]           rsp_flags,
    output logic                 busy,
    input  logic [N_REQ-1:0]     sticky_clr,
    output logic [5*N_REQ-1:0]   sticky_flags,
    output logic                 core_en,
    output logic                 core_sel,
    output logic [31:0]          core_a,
    output logic [31:0]          core_b,
    input  logic [31:0]          core_R,
    input  logic [4:0]           core_flags
);

    localparam int IDW = $clog2(N_REQ);

    logic [IDW-1:0]     r_ptr;
    logic [2*N_REQ-1:0] w_dbl;
    logic               w_gnt_vld;
    logic [IDW-1:0]     w_gnt_id;
    logic [N_REQ-1:0]   w_grant;
    logic               w_sel;
    logic [31:0]        w_a;
    logic [31:0]        w_b;

    logic               r_core_sel;
    logic [31:0]        r_core_a;
    logic [31:0]        r_core_b;

    logic [LATENCY-1:0] r_tag_vld;
    logic [IDW-1:0]     r_tag_id [LATENCY];

    logic [N_REQ-1:0]   r_rsp_valid;
    logic [31:0]        r_rsp_R;
    logic [4:0]         r_rsp_flags;

    // Round-robin search: rotating a doubled copy of req_valid right by
    // r_ptr puts the highest-priority requester at bit 0.
    always_comb begin
        w_dbl     = {req_valid, req_valid} >> r_ptr;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_gnt_vld && w_dbl[k]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = IDW'((int'(r_ptr) + k) % N_REQ);
            end
        end
        // While reset is held, nothing is granted, so ready and core_en stay 0.
        if (arst) begin
            w_gnt_vld = 1'b0;
        end
    end

    always_comb begin
        w_sel = 1'b0;
        w_a   = '0;
        w_b   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt_id == IDW'(k)) begin
                w_sel = req_sel[k];
                w_a   = req_a[32*k +: 32];
                w_b   = req_b[32*k +: 32];
            end
        end
    end

    assign w_grant = w_gnt_vld ? (N_REQ'(1) << w_gnt_id) : '0;

    // Arbitration state and the last-issued operands. core_a/b/sel show
    // these values while no op is being issued.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_ptr      <= '0;
            r_core_sel <= 1'b0;
            r_core_a   <= '0;
            r_core_b   <= '0;
        end else if (w_gnt_vld) begin
            r_ptr      <= IDW'((int'(w_gnt_id) + 1) % N_REQ);
            r_core_sel <= w_sel;
            r_core_a   <= w_a;
            r_core_b   <= w_b;
        end
    end

    // Tag pipe: shifts in step with the core pipeline, one stage per cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_tag_vld <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_gnt_vld;
            r_tag_id[0]  <= w_gnt_id;
            for (int k = 1; k < LATENCY; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

    // Response capture: the core result is valid while the tag sits in the
    // last stage.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rsp_valid <= '0;
            r_rsp_R     <= '0;
            r_rsp_flags <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_tag_vld[LATENCY-1]) begin
                r_rsp_valid <= N_REQ'(1) << r_tag_id[LATENCY-1];
                r_rsp_R     <= core_R;
                r_rsp_flags <= core_flags;
            end
        end
    end

`ifdef MUL_DIV_ARB_STICKY_FLAGS_EN
    logic [5*N_REQ-1:0] r_sticky;

    // The clear takes priority over a set in the same cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sticky <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (sticky_clr[i]) begin
                    r_sticky[5*i +: 5] <= '0;
                end else if (r_rsp_valid[i]) begin
                    r_sticky[5*i +: 5] <= r_sticky[5*i +: 5] | r_rsp_flags;
                end
            end
        end
    end

    assign sticky_flags = r_sticky;
`else
    logic w_unused_sticky_clr;

    assign w_unused_sticky_clr = ^sticky_clr;
    assign sticky_flags        = '0;
`endif

    assign req_ready = w_grant;
    assign core_en   = w_gnt_vld;
    assign core_sel  = w_gnt_vld ? w_sel : r_core_sel;
    assign core_a    = w_gnt_vld ? w_a   : r_core_a;
    assign core_b    = w_gnt_vld ? w_b   : r_core_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_R     = r_rsp_R;
    assign rsp_flags = r_rsp_flags;
    assign busy      = w_gnt_vld | (|r_tag_vld) | (|r_rsp_valid);

endmodule

// File: tb/tb_mul_div_arbiter.sv
// Testbench for mul_div_arbiter (N_REQ=2, LATENCY=2). A stand-in core returns
// exact IEEE results for the directed FP cases. For every other input it
// returns a distinctive pattern. A reference model built from a scoreboard
// queue checks every output on every cycle. Literal expectations pin the
// directed scenarios.

module tb_mul_div_arbiter;

    localparam int N = 2;
    localparam int L = 2;

    logic             clk = 1'b0;
    logic             arst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     req_sel = '0;
    logic [32*N-1:0]  req_a = '0;
    logic [32*N-1:0]  req_b = '0;
    logic [N-1:0]     rsp_valid;
    logic [31:0]      rsp_R;
    logic [4:0]       rsp_flags;
    logic             busy;
    logic [N-1:0]     sticky_clr = '0;
    logic [5*N-1:0]   sticky_flags;
    logic             core_en;
    logic             core_sel;
    logic [31:0]      core_a;
    logic [31:0]      core_b;
    logic [31:0]      core_R;
    logic [4:0]       core_flags;

    mul_div_arbiter #(.N_REQ(N), .LATENCY(L)) dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_R(rsp_R), .rsp_flags(rsp_flags),
        .busy(busy), .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
        .core_en(core_en), .core_sel(core_sel), .core_a(core_a), .core_b(core_b),
        .core_R(core_R), .core_flags(core_flags)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stand-in core: {R, flags}
    function automatic logic [36:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        if (!s && a == 32'h40000000 && b == 32'h40400000) return {32'h40C00000, 5'b00000};
        if ( s && a == 32'h3F800000 && b == 32'h00000000) return {32'h7F800000, 5'b01000};
        if (!s && a == 32'h7F000000 && b == 32'h7F000000) return {32'h7F800000, 5'b00101};
        return {a ^ {b[15:0], b[31:16]} ^ {31'd0, s}, a[4:0] ^ b[4:0]};
    endfunction

    logic [36:0] cpipe [L] = '{default: '0};

    always @(posedge clk) begin
        cpipe[0] <= core_en ? core_fn(core_a, core_b, core_sel) : 37'd0;
        for (int k = 1; k < L; k++) cpipe[k] <= cpipe[k-1];
    end

    assign core_R     = cpipe[L-1][36:5];
    assign core_flags = cpipe[L-1][4:0];

    // Reference model
    typedef struct {
        int          due;
        int          id;
        logic [31:0] r;
        logic [4:0]  f;
    } rsp_t;

    rsp_t           q[$];
    int             ptr_m = 0;
    logic [31:0]    la = '0, lb = '0, lr = '0;
    logic           ls = 1'b0;
    logic [4:0]     lf = '0;
    logic [5*N-1:0] st_m = '0;
    logic [N-1:0]   wait_m = '0;

    always @(negedge clk) begin
        int           g;
        logic [N-1:0] er;
        logic [N-1:0] erv;
        logic [36:0]  cr;
        rsp_t         e;
        if (arst) begin
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_R", 64'(rsp_R), 64'd0);
            chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_core_en", 64'(core_en), 64'd0);
            chk("rst_core_sel", 64'(core_sel), 64'd0);
            chk("rst_core_a", 64'(core_a), 64'd0);
            chk("rst_core_b", 64'(core_b), 64'd0);
            chk("rst_sticky", 64'(sticky_flags), 64'd0);
            q.delete();
            ptr_m = 0; la = '0; lb = '0; ls = 1'b0; lr = '0; lf = '0;
            st_m = '0; wait_m = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wait_m[i] && !req_valid[i]) begin
                    errors++;
                    $display("FAIL valid_drop: requester %0d dropped valid before ready (cycle %0d)", i, cyc);
                end
            end
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            chk("busy", 64'(busy), 64'((g >= 0) || (q.size() > 0)));
            chk("ready", 64'(req_ready), 64'(er));
            chk("core_en", 64'(core_en), 64'(g >= 0));
            if (g >= 0) begin
                la = req_a[32*g +: 32];
                lb = req_b[32*g +: 32];
                ls = req_sel[g];
                cr = core_fn(la, lb, ls);
                e.due = cyc + L + 1; e.id = g; e.r = cr[36:5]; e.f = cr[4:0];
                q.push_back(e);
                ptr_m = (g + 1) % N;
            end
            chk("core_a", 64'(core_a), 64'(la));
            chk("core_b", 64'(core_b), 64'(lb));
            chk("core_sel", 64'(core_sel), 64'(ls));
            erv = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                erv[q[0].id] = 1'b1;
                lr = q[0].r;
                lf = q[0].f;
                void'(q.pop_front());
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(erv));
            chk("rsp_R", 64'(rsp_R), 64'(lr));
            chk("rsp_flags", 64'(rsp_flags), 64'(lf));
`ifdef MUL_DIV_ARB_STICKY_FLAGS_EN
            chk("sticky", 64'(sticky_flags), 64'(st_m));
            for (int i = 0; i < N; i++) begin
                if (sticky_clr[i]) st_m[5*i +: 5] = '0;
                else if (erv[i])   st_m[5*i +: 5] = st_m[5*i +: 5] | lf;
            end
`else
            chk("sticky", 64'(sticky_flags), 64'd0);
`endif
            wait_m = req_valid & ~er;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]     = v;
        req_sel[i]       = s;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    initial begin
        int cnt0;
        int cnt1;
        int nrsp;
        logic [N-1:0] pat;

        repeat (2) tick();
        arst = 1'b0;
        tick();

        // Single multiply: 2.0 * 3.0
        set_req(0, 1'b1, 1'b0, 32'h40000000, 32'h40400000);
        @(negedge clk);
        chk("t2_ready", 64'(req_ready), 64'h1);
        chk("t2_core_a", 64'(core_a), 64'h40000000);
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("t2_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t2_rsp_R", 64'(rsp_R), 64'h40C00000);
        chk("t2_rsp_flags", 64'(rsp_flags), 64'h0);
        tick();

        // Divide by zero on requester 1
        set_req(1, 1'b1, 1'b1, 32'h3F800000, 32'h00000000);
        @(negedge clk);
        chk("t4_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("t4_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("t4_rsp_R", 64'(rsp_R), 64'h7F800000);
        chk("t4_rsp_flags", 64'(rsp_flags), 64'h08);
        tick();
`ifdef MUL_DIV_ARB_STICKY_FLAGS_EN
        @(negedge clk);
        chk("t4_sticky_set", 64'(sticky_flags[9:5]), 64'h08);
        tick();
        @(negedge clk);
        chk("t4_sticky_hold", 64'(sticky_flags[9:5]), 64'h08);
        sticky_clr[1] = 1'b1;
        tick();
        sticky_clr[1] = 1'b0;
        @(negedge clk);
        chk("t4_sticky_clr", 64'(sticky_flags[9:5]), 64'h00);
        tick();
`endif

        // Contention: both requesters valid, new operands after each grant
        cnt0 = 0;
        cnt1 = 0;
        for (int n = 0; n < 11; n++) begin
            if (n < 6) begin
                set_req(0, 1'b1, 1'b0, 32'h3F800000 + 32'(cnt0), 32'h40000000 + 32'(cnt0 * 7));
                set_req(1, 1'b1, 1'b1, 32'h42000000 + 32'(cnt1), 32'h3E000000 + 32'(cnt1 * 5));
            end else if (n == 6) begin
                set_req(0, 1'b1, 1'b0, 32'h3F800000 + 32'(cnt0), 32'h40000000 + 32'(cnt0 * 7));
                req_valid[1] = 1'b0;
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            if (n <= 6) begin
                pat = (n % 2 == 0) ? 2'b01 : 2'b10;
                chk("t3_grant", 64'(req_ready), 64'(pat));
            end
            if (n >= 3 && n <= 9) begin
                pat = ((n - 3) % 2 == 0) ? 2'b01 : 2'b10;
                chk("t3_rsp_id", 64'(rsp_valid), 64'(pat));
            end
            if (n == 10) chk("t3_rsp_done", 64'(rsp_valid), 64'h0);
            if (req_ready[0]) cnt0++;
            if (req_ready[1]) cnt1++;
            tick();
        end

        // Back-to-back on requester 1
        for (int n = 0; n < 8; n++) begin
            if (n < 4) set_req(1, 1'b1, n[0], 32'h41000000 + 32'(n), 32'h3F000000 + 32'(n * 3));
            else req_valid = '0;
            @(negedge clk);
            if (n < 4) chk("t5_ready", 64'(req_ready), 64'h2);
            if (n >= 3 && n <= 6) chk("t5_rsp_valid", 64'(rsp_valid), 64'h2);
            if (n == 7) chk("t5_rsp_done", 64'(rsp_valid), 64'h0);
            tick();
        end

        // Overflow on requester 0 with a clear landing on the response cycle
        set_req(0, 1'b1, 1'b0, 32'h7F000000, 32'h7F000000);
        @(negedge clk);
        chk("t6_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        sticky_clr[0] = 1'b1;
        @(negedge clk);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t6_rsp_flags", 64'(rsp_flags), 64'h05);
        tick();
        sticky_clr[0] = 1'b0;
        @(negedge clk);
        chk("t6_sticky_clr_wins", 64'(sticky_flags[4:0]), 64'h00);
        tick();

        // Reset with two ops in flight
        set_req(0, 1'b1, 1'b0, 32'h11111111, 32'h22222222);
        set_req(1, 1'b1, 1'b1, 32'h33333333, 32'h44444444);
        @(negedge clk);
        chk("t1_grant_a", 64'(req_ready), 64'h2);
        tick();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("t1_grant_b", 64'(req_ready), 64'h1);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_busy_inflight", 64'(busy), 64'h1);
        tick();
        arst = 1'b1;
        #1;
        chk("t1_busy_in_reset", 64'(busy), 64'h0);
        chk("t1_core_a_in_reset", 64'(core_a), 64'h0);
        tick();
        tick();
        arst = 1'b0;
        nrsp = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (rsp_valid != '0) nrsp++;
            tick();
        end
        chk("t1_no_rsp_after_reset", 64'(nrsp), 64'h0);

        // Pointer restarts at requester 0 after reset
        set_req(0, 1'b1, 1'b0, 32'h40000000, 32'h40400000);
        set_req(1, 1'b1, 1'b0, 32'h40400000, 32'h40000000);
        @(negedge clk);
        chk("t1_ptr_reset", 64'(req_ready), 64'h1);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_ptr_next", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
